// File: rtl/mux_pkg.sv
// Shared defaults and helpers for the round-robin multiplexer.
//   DefWidth / DefNch : default data width and channel count
//   sel_w()           : width of a channel index, never narrower than one bit
package mux_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefNch   = 4;

  function automatic int unsigned sel_w(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational grant selection.
//   eligible  : per-channel request after masking
//   ptr       : round-robin search start (ignored when RR == 0)
//   grant     : index of the winning channel (0 when grant_any == 0)
//   grant_any : at least one channel is eligible
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned NCH  = DefNch,
  parameter int unsigned SELW = sel_w(NCH),
  parameter int unsigned RR   = 1
) (
  input  logic [NCH-1:0]  eligible,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            grant_any
);

  logic [31:0]     pos;
  logic [SELW-1:0] idx;

  // Scan NCH candidates starting at ptr (or at 0 for fixed priority); first hit wins.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    pos       = '0;
    idx       = '0;
    for (int k = 0; k < NCH; k++) begin
      if (RR != 0) begin
        pos = (32'(ptr) + 32'(k)) % NCH;
      end else begin
        pos = 32'(k);
      end
      idx = pos[SELW-1:0];
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant     = idx;
      end
    end
  end

endmodule

// File: rtl/rr_mux.sv
// N-to-1 multiplexer with round-robin (or fixed-priority) arbitration feeding a
// single registered output slot.
//   clk, rst   : clock and synchronous active-high reset
//   in_data    : NCH packed channels, channel i at [i*WIDTH +: WIDTH]
//   in_valid   : per-channel request
//   in_ready   : per-channel accept, one-hot or zero
//   force_en   : restrict eligibility to channel force_sel only
//   force_sel  : forced channel index (out-of-range selects nothing)
//   out_data   : registered word, out_ch its source channel
//   out_valid  : slot holds an undelivered word
//   out_ready  : downstream accept
module rr_mux
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH = DefWidth,
  parameter  int unsigned NCH   = DefNch,
  parameter  int unsigned RR    = 1,
  localparam int unsigned SELW  = sel_w(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 force_en,
  input  logic [SELW-1:0]      force_sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;

  logic             load_ok;
  logic             xfer;
  logic [NCH-1:0]   eligible;
  logic [SELW-1:0]  grant;
  logic             grant_any;

  // Slot can accept when empty or being drained this cycle.
  assign load_ok = !out_valid_q || out_ready;

  // A force_sel beyond NCH-1 matches no channel, leaving the set empty.
  always_comb begin
    eligible = in_valid;
    if (force_en) begin
      eligible = '0;
      for (int i = 0; i < NCH; i++) begin
        if (force_sel == SELW'(i)) begin
          eligible[i] = in_valid[i];
        end
      end
    end
  end

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW),
    .RR   (RR)
  ) u_arbiter (
    .eligible  (eligible),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_any (grant_any)
  );

  // Reset blocks the handshake so no word is consumed that the slot then drops.
  assign xfer = grant_any && load_ok && !rst;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      if (xfer && (grant == SELW'(i))) begin
        in_ready[i] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (load_ok) begin
      out_valid_d = xfer;
    end
    if (xfer) begin
      out_ch_d = grant;
      for (int i = 0; i < NCH; i++) begin
        if (grant == SELW'(i)) begin
          out_data_d = in_data[i*WIDTH +: WIDTH];
        end
      end
      if (RR != 0) begin
        ptr_d = (grant == SELW'(NCH - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux.sv
// Bench for rr_mux: a default round-robin build checked against a behavioural
// model, plus a fixed-priority build and a 2-channel 8-bit build on shared clock/reset.
module tb_rr_mux;

  localparam int W = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Main round-robin instance
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic           force_en;
  logic [1:0]     force_sel;
  logic [W-1:0]   out_data;
  logic [1:0]     out_ch;
  logic           out_valid, out_ready;

  rr_mux #(.WIDTH(W), .NCH(N), .RR(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .force_en(force_en), .force_sel(force_sel), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // Fixed-priority instance
  logic [N*W-1:0] data_fp;
  logic [N-1:0]   valid_fp, ready_fp;
  logic [W-1:0]   out_data_fp;
  logic [1:0]     out_ch_fp;
  logic           out_valid_fp;
  logic           fe_fp = 1'b0;
  logic [1:0]     fs_fp = 2'd0;
  logic           ordy_fp = 1'b1;

  rr_mux #(.WIDTH(W), .NCH(N), .RR(0)) dut_fp (
    .clk(clk), .rst(rst), .in_data(data_fp), .in_valid(valid_fp), .in_ready(ready_fp),
    .force_en(fe_fp), .force_sel(fs_fp), .out_data(out_data_fp), .out_ch(out_ch_fp),
    .out_valid(out_valid_fp), .out_ready(ordy_fp)
  );

  // Two-channel, 8-bit instance
  logic [15:0] data2;
  logic [1:0]  valid2, ready2;
  logic [7:0]  out_data2;
  logic        out_ch2;
  logic        out_valid2;
  logic        fe2 = 1'b0;
  logic        fs2 = 1'b0;
  logic        ordy2 = 1'b1;

  rr_mux #(.WIDTH(8), .NCH(2), .RR(1)) dut2 (
    .clk(clk), .rst(rst), .in_data(data2), .in_valid(valid2), .in_ready(ready2),
    .force_en(fe2), .force_sel(fs2), .out_data(out_data2), .out_ch(out_ch2),
    .out_valid(out_valid2), .out_ready(ordy2)
  );

  // Reference model state for the main instance
  bit          m_valid;
  logic [31:0] m_data;
  int          m_ch;
  int          m_ptr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walk the channels starting at the pointer; the first requester that is allowed wins.
  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (in_valid[c] && (!force_en || int'(force_sel) == c)) return c;
    end
    return -1;
  endfunction

  // Inputs are set just after a rising edge; check in_ready mid-cycle, then the slot after the edge.
  task automatic step();
    int         g;
    bit         load_ok;
    logic [3:0] exp_rdy;
    #3;
    g       = model_grant();
    load_ok = !m_valid || out_ready;
    exp_rdy = '0;
    if (!rst && load_ok && g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_ch    = 0;
      m_ptr   = 0;
    end else if (load_ok) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*W +: W];
        m_ch    = g;
        m_ptr   = (g + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_ch", 64'(out_ch), 64'(m_ch));
    chk("out_data", 64'(out_data), 64'(m_data));
  endtask

  initial begin
    m_valid   = 1'b0;
    m_data    = '0;
    m_ch      = 0;
    m_ptr     = 0;
    rst       = 1'b1;
    in_data   = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
    in_valid  = 4'b1111;
    force_en  = 1'b0;
    force_sel = 2'd0;
    out_ready = 1'b1;
    data_fp   = {32'hF3F3_F3F3, 32'hF2F2_F2F2, 32'hF1F1_F1F1, 32'hF0F0_F0F0};
    valid_fp  = 4'b1010;
    data2     = {8'hB1, 8'hA0};
    valid2    = 2'b11;

    // Reset: everything empty, no in_ready while rst is high
    repeat (2) begin
      step();
      chk("rst_ready_fp", 64'(ready_fp), 64'd0);
      chk("rst_ready2", 64'(ready2), 64'd0);
      chk("rst_valid_fp", 64'(out_valid_fp), 64'd0);
      chk("rst_data2", 64'(out_data2), 64'd0);
    end
    rst = 1'b0;

    // All channels requesting: rotation 0,1,2,3,0; fixed priority locks onto 1; 2-ch alternates
    for (int i = 0; i < 5; i++) begin
      logic [7:0] exp2;
      step();
      chk("rr_seq", 64'(out_ch), 64'(i % 4));
      chk("rr_valid", 64'(out_valid), 64'd1);
      chk("fp_ch", 64'(out_ch_fp), 64'd1);
      chk("fp_data", 64'(out_data_fp), 64'hF1F1_F1F1);
      chk("fp_ready", 64'(ready_fp), 64'(4'b0010));
      exp2 = (i % 2 == 0) ? 8'hA0 : 8'hB1;
      chk("nch2_ch", 64'(out_ch2), 64'(i % 2));
      chk("nch2_data", 64'(out_data2), 64'(exp2));
    end

    // Fill slot with DEADBEEF then stall for three cycles
    in_data[31:0] = 32'hDEAD_BEEF;
    in_valid      = 4'b0001;
    step();
    chk("load_beef", 64'(out_data), 64'hDEAD_BEEF);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    repeat (3) begin
      step();
      chk("hold_data", 64'(out_data), 64'hDEAD_BEEF);
    end

    // Forced selection: only channel 2 may go
    out_ready = 1'b1;
    force_en  = 1'b1;
    force_sel = 2'd2;
    step();
    chk("force_ch", 64'(out_ch), 64'd2);
    // Forced channel idle: nothing eligible, slot drains but keeps its data
    in_valid = 4'b1011;
    step();
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_data", 64'(out_data), 64'h2222_0002);
    // Release force: pointer continues after channel 2
    force_en = 1'b0;
    in_valid = 4'b1111;
    step();
    chk("after_force", 64'(out_ch), 64'd3);

    // Reset while a word sits in the slot and channel 1 is requesting
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_data", 64'(out_data), 64'd0);
    rst       = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    step();
    chk("first_after_rst", 64'(out_ch), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_valid  = 4'($urandom);
      out_ready = ($urandom % 4) != 0;
      force_en  = ($urandom % 4) == 0;
      force_sel = 2'($urandom);
      rst       = ($urandom % 50) == 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
